// File: rtl/signed_divider_seq.sv
// Multi-cycle signed integer divider: restoring division, one quotient bit per cycle, then sign correction.
// Ports: clock/reset (async, active-high); ctrl_DIV starts a division and is sampled only when idle.
//        data_operandA/B are the signed operands, captured on the start edge.
//        data_result/data_remainder/data_exception are registered and held until the next completion.
//        data_resultRDY pulses for one cycle at completion; busy is high while an operation is in flight.
module signed_divider_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_CORRECT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  // Captured operand information
  logic             r_signA;
  logic             r_signB;
  logic             r_bZero;
  logic             r_ovf;
  logic [WIDTH-1:0] r_magB;

  // Iteration state: r_quo starts as |A| and shifts out dividend bits MSB first
  // while quotient bits shift in at the bottom.
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;

  // Output registers
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_remainder;
  logic             r_exc;
  logic             r_rdy;

  logic [WIDTH-1:0] w_magA;
  logic [WIDTH-1:0] w_magB;
  logic             w_aZero;
  logic             w_bZero;
  logic             w_ovf;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_last;

  // Negating the most negative value wraps back to itself, which read as
  // unsigned is exactly 2^(WIDTH-1), so a plain negate gives the magnitude.
  assign w_magA  = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign w_magB  = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign w_aZero = (data_operandA == '0);
  assign w_bZero = (data_operandB == '0);
  // Only -2^(WIDTH-1) / -1 has a quotient that cannot be represented.
  assign w_ovf   = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);

  // The partial remainder stays below |B| <= 2^(WIDTH-1), so after shifting it
  // fits in WIDTH bits; the extra top bit of the trial difference is its sign.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_magB};
  assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (ctrl_DIV) begin
          w_next = (w_aZero || w_bZero) ? S_DONE : S_ITER;
        end
      end
      S_ITER: begin
        if (w_last) begin
          w_next = S_CORRECT;
        end
      end
      S_CORRECT: w_next = S_IDLE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_signA     <= 1'b0;
      r_signB     <= 1'b0;
      r_bZero     <= 1'b0;
      r_ovf       <= 1'b0;
      r_magB      <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_remainder <= '0;
      r_exc       <= 1'b0;
      r_rdy       <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ctrl_DIV) begin
            r_signA <= data_operandA[WIDTH-1];
            r_signB <= data_operandB[WIDTH-1];
            r_bZero <= w_bZero;
            r_ovf   <= w_ovf;
            r_magB  <= w_magB;
            r_quo   <= w_magA;
            r_rem   <= '0;
            r_cnt   <= '0;
          end
        end
        S_ITER: begin
          if (!w_trial[WIDTH]) begin
            r_rem <= w_trial[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= w_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_CORRECT: begin
          // Truncating division: quotient sign is the XOR of operand signs,
          // remainder follows the dividend. The overflow case wraps naturally.
          r_result    <= (r_signA ^ r_signB) ? -r_quo : r_quo;
          r_remainder <= r_signA ? -r_rem : r_rem;
          r_exc       <= r_ovf;
          r_rdy       <= 1'b1;
        end
        S_DONE: begin
          // Zero dividend or zero divisor: both results are zero; only a
          // zero divisor raises the exception.
          r_result    <= '0;
          r_remainder <= '0;
          r_exc       <= r_bZero;
          r_rdy       <= 1'b1;
        end
        default: begin
          r_rdy <= 1'b0;
        end
      endcase
    end
  end

  assign data_result    = r_result;
  assign data_remainder = r_remainder;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  // busy drops on the same edge that raises data_resultRDY, which is the edge
  // returning the FSM to IDLE.
  assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_signed_divider_seq.sv
module tb_signed_divider_seq;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        start32 = 1'b0;
  logic [31:0] a32 = '0;
  logic [31:0] b32 = '0;
  logic [31:0] res32, rem32;
  logic        exc32, rdy32, busy32;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic [7:0]  res8, rem8;
  logic        exc8, rdy8, busy8;

  int checks = 0;
  int errors = 0;

  signed_divider_seq #(.WIDTH(32)) dut32 (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (start32),
    .data_operandA  (a32),
    .data_operandB  (b32),
    .data_result    (res32),
    .data_remainder (rem32),
    .data_exception (exc32),
    .data_resultRDY (rdy32),
    .busy           (busy32)
  );

  signed_divider_seq #(.WIDTH(8)) dut8 (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (start8),
    .data_operandA  (a8),
    .data_operandB  (b8),
    .data_result    (res8),
    .data_remainder (rem8),
    .data_exception (exc8),
    .data_resultRDY (rdy8),
    .busy           (busy8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: truncating signed division done in 64-bit arithmetic, so the
  // single overflow case simply yields 2^(w-1), which wraps when masked to w bits.
  function automatic void model(input int w, input longint a, input longint b,
                                output longint q, output longint r, output bit e);
    longint minv;
    minv = -(longint'(1) << (w - 1));
    if (b == 0) begin
      q = 0; r = 0; e = 1'b1;
    end else if (a == 0) begin
      q = 0; r = 0; e = 1'b0;
    end else begin
      q = a / b;
      r = a % b;
      e = (a == minv) && (b == -1);
    end
  endfunction

  task automatic set_start(input bit w8, input bit v, input longint a, input longint b);
    if (w8) begin
      start8 = v; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start32 = v; a32 = a[31:0]; b32 = b[31:0];
    end
  endtask

  // Issues a start at the current negedge and returns at the negedge on which
  // data_resultRDY is observed, so a following call starts back-to-back.
  // glitch_at > 0 pulses ctrl_DIV with junk operands while the divider is busy.
  task automatic run_op(input bit w8, input longint a, input longint b,
                        input int glitch_at, input string tag);
    int          w;
    int          n;
    int          lat;
    longint      q, r;
    bit          e;
    logic [63:0] mask;
    w    = w8 ? 8 : 32;
    mask = w8 ? 64'hFF : 64'hFFFF_FFFF;
    model(w, a, b, q, r, e);
    lat = (a == 0 || b == 0) ? 1 : w + 1;
    set_start(w8, 1'b1, a, b);
    @(negedge clock);
    // Operands are scrambled after the start edge; the result must not care.
    set_start(w8, 1'b0, longint'($urandom), longint'($urandom));
    chk({tag, "_busy_start"}, 64'(w8 ? busy8 : busy32), 64'd1);
    n = 0;
    while (!(w8 ? rdy8 : rdy32) && n < 200) begin
      set_start(w8, (glitch_at > 0) && (n == glitch_at),
                longint'($urandom), longint'($urandom));
      @(negedge clock);
      n++;
    end
    set_start(w8, 1'b0, 0, 0);
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    chk({tag, "_busy_done"}, 64'(w8 ? busy8 : busy32), 64'd0);
    chk({tag, "_q"}, 64'(w8 ? 32'(res8) : res32) & mask, 64'(q) & mask);
    chk({tag, "_r"}, 64'(w8 ? 32'(rem8) : rem32) & mask, 64'(r) & mask);
    chk({tag, "_exc"}, 64'(w8 ? exc8 : exc32), 64'(e));
  endtask

  task automatic after_op(input bit w8, input string tag);
    @(negedge clock);
    chk({tag, "_rdy_drop"}, 64'(w8 ? rdy8 : rdy32), 64'd0);
  endtask

  initial begin
    logic [7:0] ra, rb;
    bit         seen;

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_res32", 64'(res32), 64'd0);
    chk("rst_rem32", 64'(rem32), 64'd0);
    chk("rst_exc32", 64'(exc32), 64'd0);
    chk("rst_rdy32", 64'(rdy32), 64'd0);
    chk("rst_busy32", 64'(busy32), 64'd0);
    chk("rst_busy8", 64'(busy8), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // Basic 32-bit division
    run_op(1'b0, 100, 7, 0, "d100_7");
    after_op(1'b0, "d100_7");

    // Back-to-back: second start issued in the RDY cycle
    run_op(1'b0, -10, 3, 0, "dm10_3");
    run_op(1'b0, -15, -15, 0, "dm15_m15");
    after_op(1'b0, "dm15_m15");

    // Fast paths
    run_op(1'b0, 0, 8, 0, "d0_8");
    after_op(1'b0, "d0_8");
    run_op(1'b0, 100, 0, 0, "d100_0");
    after_op(1'b0, "d100_0");
    run_op(1'b0, 0, 0, 0, "d0_0");
    after_op(1'b0, "d0_0");

    // Most negative dividend
    run_op(1'b0, -64'sd2147483648, -1, 0, "dmin_m1");
    after_op(1'b0, "dmin_m1");
    run_op(1'b0, -64'sd2147483648, 2, 0, "dmin_2");
    after_op(1'b0, "dmin_2");

    // Reset in the middle of an operation
    set_start(1'b0, 1'b1, 1000, 3);
    @(negedge clock);
    set_start(1'b0, 1'b0, 0, 0);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort_res", 64'(res32), 64'd0);
    chk("abort_rem", 64'(rem32), 64'd0);
    chk("abort_exc", 64'(exc32), 64'd0);
    chk("abort_busy", 64'(busy32), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (rdy32) seen = 1'b1;
    end
    chk("abort_no_rdy", 64'(seen), 64'd0);
    run_op(1'b0, 9, -4, 0, "d9_m4");
    after_op(1'b0, "d9_m4");

    // 8-bit instance: overflow, busy-time start requests, random sweep
    run_op(1'b1, -128, -1, 0, "w8_min_m1");
    after_op(1'b1, "w8_min_m1");
    run_op(1'b1, 77, -5, 3, "w8_glitch");
    after_op(1'b1, "w8_glitch");
    run_op(1'b1, -128, 0, 0, "w8_min_0");
    after_op(1'b1, "w8_min_0");
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i % 50 == 7) rb = 8'h00;
      if (i % 50 == 13) ra = 8'h00;
      run_op(1'b1, longint'($signed(ra)), longint'($signed(rb)), 0, "w8_rand");
      if (i % 3 != 0) @(negedge clock);
    end
    after_op(1'b1, "w8_rand_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
